// File: rtl/sport_pkg.sv
// sport_pkg: shared widths, limits and captured-configuration type for the SPORT lane engine
package sport_pkg;
  localparam int DW_DEF = 16;
  localparam int NSLOT_DEF = 32;
  localparam int DIVW_DEF = 16;
  localparam int SLEN_W = $clog2(DW_DEF);
  localparam int SLOT_W = $clog2(NSLOT_DEF);
  localparam int SLEN_MIN = 2;
  typedef struct packed {
    logic [DIVW_DEF-1:0] div;
    logic [SLEN_W-1:0] slen;
    logic mce;
    logic [SLOT_W-1:0] slots_m1;
    logic lsbf;
  } cfg_t;
  function automatic logic [SLEN_W-1:0] eff_slen(input logic [SLEN_W-1:0] s);
    return s < SLEN_W'(SLEN_MIN) ? SLEN_W'(SLEN_MIN) : s;
  endfunction
endpackage

// File: rtl/sport_sclk_gen.sv
// sport_sclk_gen: SCLK divider producing alternating rise/fall ticks, cleared while disabled
module sport_sclk_gen #(
  parameter int DIVW = 16
) (
  input  logic            DSPCLK,
  input  logic            RST,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            sclk,
  output logic            rise,
  output logic            fall
);
  logic [DIVW-1:0] cnt;
  logic tick;
  assign tick = en && cnt == div;
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  always_ff @(posedge DSPCLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sclk <= ~sclk;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/sport_lane_engine.sv
// sport_lane_engine: SPORT serial shift engine with SCLK/FS generation and TDM slot masking
// Define SPORT_LSBF_EN to add the LSBF port for LSB-first framing.
module sport_lane_engine
  import sport_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NSLOT = NSLOT_DEF,
  parameter int DIVW = DIVW_DEF
) (
  input  logic                     DSPCLK,
  input  logic                     RST,
  input  logic                     SP_EN,
  input  logic [DIVW-1:0]          SCLKDIV,
  input  logic [$clog2(DW)-1:0]    SLEN,
  input  logic                     MCE,
  input  logic [$clog2(NSLOT)-1:0] SLOTS_M1,
  input  logic [NSLOT-1:0]         TSLOT_MASK,
  input  logic [NSLOT-1:0]         RSLOT_MASK,
  input  logic                     LOOP,
  input  logic [DW-1:0]            TX_DATA,
  input  logic                     TX_VALID,
  output logic                     TX_READY,
  output logic [DW-1:0]            RX_DATA,
  output logic                     RX_VALID,
  input  logic                     RX_READY,
  output logic                     TX_UFL,
  output logic                     RX_OVF,
  input  logic                     RDx,
  output logic                     TDx,
  output logic                     SCLKo,
  output logic                     FSo,
  output logic [$clog2(NSLOT)-1:0] SLOT_NUM
`ifdef SPORT_LSBF_EN
  ,
  input  logic                     LSBF
`endif
);
  localparam int SW = $clog2(DW);
  localparam int TW = $clog2(NSLOT);
  cfg_t cfg;
  logic sp_en_d, en, rise, fall, start, bit_last, slot_last, tmask, rmask, take;
  logic tx_full, tx_bit, rx_en, done, rd, lsbf_in;
  logic [SW-1:0] bit_cnt, idx;
  logic [TW-1:0] msel;
  logic [DW-1:0] tx_buf, tx_sh, word, rx_sh, rx_base, rx_next;
`ifdef SPORT_LSBF_EN
  assign lsbf_in = LSBF;
`else
  assign lsbf_in = 1'b0;
`endif
  // The first enabled cycle only captures config; counting starts the cycle after.
  assign en = SP_EN && sp_en_d;
  sport_sclk_gen #(.DIVW(DIVW)) u_sclk (
    .DSPCLK(DSPCLK),
    .RST(RST),
    .en(en),
    .div(cfg.div),
    .sclk(SCLKo),
    .rise(rise),
    .fall(fall)
  );
  assign bit_last = bit_cnt == cfg.slen;
  assign slot_last = SLOT_NUM == cfg.slots_m1;
  assign start = rise && bit_cnt == '0;
  assign msel = cfg.mce ? SLOT_NUM : '0;
  assign tmask = TSLOT_MASK[msel];
  assign rmask = RSLOT_MASK[msel];
  assign take = start && tmask && tx_full;
  // A consuming slot start frees the buffer in the same cycle, so a new word can land at once.
  assign TX_READY = !tx_full || take;
  assign word = start ? (take ? tx_buf : '0) : tx_sh;
  assign idx = cfg.lsbf ? bit_cnt : cfg.slen - bit_cnt;
  assign rd = LOOP ? tx_bit : RDx;
  assign rx_base = bit_cnt == '0 ? '0 : rx_sh;
  assign rx_next = cfg.lsbf ? rx_base | (DW'(rd) << bit_cnt) : {rx_base[DW-2:0], rd};
  assign done = fall && bit_last && rx_en;
  assign TDx = !LOOP && tx_bit;
  always_ff @(posedge DSPCLK or posedge RST)
    if (RST) begin
      sp_en_d <= 1'b0;
      cfg <= '0;
      tx_buf <= '0;
      tx_full <= 1'b0;
      tx_sh <= '0;
      tx_bit <= 1'b0;
      rx_sh <= '0;
      rx_en <= 1'b0;
      bit_cnt <= '0;
      SLOT_NUM <= '0;
      FSo <= 1'b0;
      RX_DATA <= '0;
      RX_VALID <= 1'b0;
      TX_UFL <= 1'b0;
      RX_OVF <= 1'b0;
    end else begin
      sp_en_d <= SP_EN;
      TX_UFL <= 1'b0;
      RX_OVF <= 1'b0;
      if (SP_EN && !sp_en_d)
        cfg <= '{div: SCLKDIV, slen: eff_slen(SLEN), mce: MCE, slots_m1: SLOTS_M1, lsbf: lsbf_in};
      if (TX_VALID && TX_READY) begin
        tx_buf <= TX_DATA;
        tx_full <= 1'b1;
      end else if (take)
        tx_full <= 1'b0;
      if (done && (!RX_VALID || RX_READY)) begin
        RX_DATA <= rx_next;
        RX_VALID <= 1'b1;
      end else if (RX_VALID && RX_READY)
        RX_VALID <= 1'b0;
      if (!en) begin
        bit_cnt <= '0;
        SLOT_NUM <= '0;
        FSo <= 1'b0;
        tx_sh <= '0;
        tx_bit <= 1'b0;
        rx_sh <= '0;
        rx_en <= 1'b0;
      end else begin
        if (rise) begin
          tx_bit <= word[idx];
          FSo <= bit_cnt == '0 && SLOT_NUM == '0;
        end
        if (start) begin
          tx_sh <= word;
          rx_en <= rmask;
          TX_UFL <= tmask && !tx_full;
        end
        if (fall) begin
          rx_sh <= rx_next;
          RX_OVF <= done && RX_VALID && !RX_READY;
          bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
          if (bit_last)
            SLOT_NUM <= (!cfg.mce || slot_last) ? '0 : SLOT_NUM + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_sport_lane_engine.sv
// tb_sport_lane_engine: directed self-checking bench for sport_lane_engine
module tb_sport_lane_engine;
  logic DSPCLK = 1'b0, RST = 1'b1, SP_EN = 1'b0, MCE = 1'b0, LOOP = 1'b0;
  logic TX_VALID = 1'b0, RX_READY = 1'b1, RDx = 1'b0;
  logic [15:0] SCLKDIV = 16'd1;
  logic [3:0] SLEN = 4'd7;
  logic [4:0] SLOTS_M1 = 5'd0;
  logic [31:0] TSLOT_MASK = 32'hFFFF_FFFF, RSLOT_MASK = 32'h0;
  logic [15:0] TX_DATA = 16'h0;
  logic TX_READY, RX_VALID, TX_UFL, RX_OVF, TDx, SCLKo, FSo;
  logic [15:0] RX_DATA;
  logic [4:0] SLOT_NUM;
  logic [7:0] pat;
  int passed = 0, total = 0;

  sport_lane_engine dut (
    .DSPCLK(DSPCLK), .RST(RST), .SP_EN(SP_EN), .SCLKDIV(SCLKDIV), .SLEN(SLEN),
    .MCE(MCE), .SLOTS_M1(SLOTS_M1), .TSLOT_MASK(TSLOT_MASK), .RSLOT_MASK(RSLOT_MASK),
    .LOOP(LOOP), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY), .TX_UFL(TX_UFL),
    .RX_OVF(RX_OVF), .RDx(RDx), .TDx(TDx), .SCLKo(SCLKo), .FSo(FSo), .SLOT_NUM(SLOT_NUM)
`ifdef SPORT_LSBF_EN
    , .LSBF(1'b0)
`endif
  );

  always #5 DSPCLK = ~DSPCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge DSPCLK);
    #2;
  endtask

  task automatic load(input logic [15:0] d);
    TX_DATA = d;
    TX_VALID = 1'b1;
    cyc(1);
    TX_VALID = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_sclk", 32'(SCLKo), 0);
    chk("rst_fs", 32'(FSo), 0);
    chk("rst_td", 32'(TDx), 0);
    chk("rst_rxv", 32'(RX_VALID), 0);
    chk("rst_txr", 32'(TX_READY), 1);
    chk("rst_rxd", 32'(RX_DATA), 0);
    chk("rst_slot", 32'(SLOT_NUM), 0);
    chk("rst_ufl", 32'(TX_UFL), 0);
    chk("rst_ovf", 32'(RX_OVF), 0);
    RST = 1'b0;
    cyc(1);
    // basic MSB-first transmit of 0xA5, SCLK = DSPCLK/4
    load(16'h00A5);
    chk("tx_buf_full", 32'(TX_READY), 0);
    SP_EN = 1'b1;
    cyc(3);
    chk("tx_b0", 32'(TDx), 1);
    chk("tx_fs_hi", 32'(FSo), 1);
    chk("tx_sclk_hi", 32'(SCLKo), 1);
    chk("tx_consumed", 32'(TX_READY), 1);
    pat = 8'hA5;
    for (int k = 1; k < 8; k++) begin
      cyc(4);
      chk("tx_bit", 32'(TDx), 32'(pat[7-k]));
      chk("tx_fs_lo", 32'(FSo), 0);
    end
    cyc(4);
    chk("ufl_pulse", 32'(TX_UFL), 1);
    chk("ufl_zero", 32'(TDx), 0);
    chk("fs_next", 32'(FSo), 1);
    cyc(1);
    chk("ufl_once", 32'(TX_UFL), 0);
    SP_EN = 1'b0;
    cyc(1);
    chk("dis_sclk", 32'(SCLKo), 0);
    chk("dis_fs", 32'(FSo), 0);
    // loopback, then overflow, then completion coinciding with RX_READY
    LOOP = 1'b1;
    RSLOT_MASK = 32'h1;
    RX_READY = 1'b0;
    load(16'h00A5);
    SP_EN = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      chk("lb_td", 32'(TDx), 0);
      chk("lb_rxv", 32'(RX_VALID), 32'(i == 7));
    end
    chk("lb_rxd", 32'(RX_DATA), 32'h00A5);
    cyc(2);
    chk("lb_ufl", 32'(TX_UFL), 1);
    cyc(1);
    load(16'h003C);
    cyc(28);
    chk("ovf_pulse", 32'(RX_OVF), 1);
    chk("ovf_hold", 32'(RX_DATA), 32'h00A5);
    chk("ovf_valid", 32'(RX_VALID), 1);
    cyc(1);
    chk("ovf_once", 32'(RX_OVF), 0);
    cyc(30);
    RX_READY = 1'b1;
    cyc(1);
    chk("sim_valid", 32'(RX_VALID), 1);
    chk("sim_data", 32'(RX_DATA), 32'h003C);
    chk("sim_no_ovf", 32'(RX_OVF), 0);
    cyc(1);
    chk("rx_drained", 32'(RX_VALID), 0);
    SP_EN = 1'b0;
    cyc(1);
    // multichannel, 4 slots, TX in slots 0/2, RX in slot 2
    MCE = 1'b1;
    SLOTS_M1 = 5'd3;
    TSLOT_MASK = 32'h5;
    RSLOT_MASK = 32'h4;
    RX_READY = 1'b0;
    load(16'h0011);
    TX_DATA = 16'h0022;
    TX_VALID = 1'b1;
    SP_EN = 1'b1;
    cyc(3);
    chk("mc_refill", 32'(TX_READY), 0);
    chk("mc_fs", 32'(FSo), 1);
    chk("mc_slot0", 32'(SLOT_NUM), 0);
    TX_VALID = 1'b0;
    cyc(30);
    chk("mc_slot1", 32'(SLOT_NUM), 1);
    chk("mc_rx0", 32'(RX_VALID), 0);
    cyc(32);
    chk("mc_slot2", 32'(SLOT_NUM), 2);
    chk("mc_rx1", 32'(RX_VALID), 0);
    cyc(2);
    chk("mc_take2", 32'(TX_READY), 1);
    cyc(30);
    chk("mc_slot3", 32'(SLOT_NUM), 3);
    chk("mc_rx2v", 32'(RX_VALID), 1);
    chk("mc_rx2d", 32'(RX_DATA), 32'h0022);
    cyc(2);
    chk("mc_no_ufl3", 32'(TX_UFL), 0);
    chk("mc_td", 32'(TDx), 0);
    cyc(32);
    chk("mc_wrap", 32'(SLOT_NUM), 0);
    chk("mc_fs2", 32'(FSo), 1);
    chk("mc_ufl0", 32'(TX_UFL), 1);
    SP_EN = 1'b0;
    RX_READY = 1'b1;
    cyc(2);
    // 3-bit word at SCLK = DSPCLK/2; bit 3 of 0xD lies outside the word
    MCE = 1'b0;
    TSLOT_MASK = 32'h1;
    RSLOT_MASK = 32'h1;
    SLEN = 4'd1;
    SCLKDIV = 16'd0;
    load(16'h000D);
    SP_EN = 1'b1;
    cyc(2);
    chk("d0_sclk1", 32'(SCLKo), 1);
    cyc(1);
    chk("d0_sclk2", 32'(SCLKo), 0);
    cyc(1);
    chk("d0_sclk3", 32'(SCLKo), 1);
    cyc(1);
    chk("w3_pend", 32'(RX_VALID), 0);
    cyc(2);
    chk("w3_valid", 32'(RX_VALID), 1);
    chk("w3_data", 32'(RX_DATA), 32'h0005);
    SP_EN = 1'b0;
    cyc(1);
    // full 16-bit word
    SLEN = 4'd15;
    RX_READY = 1'b0;
    load(16'hBEEF);
    SP_EN = 1'b1;
    cyc(31);
    chk("w16_pend", 32'(RX_VALID), 0);
    cyc(2);
    chk("w16_valid", 32'(RX_VALID), 1);
    chk("w16_data", 32'(RX_DATA), 32'hBEEF);
    SP_EN = 1'b0;
    cyc(1);
    // disable in the middle of a word, then asynchronous reset
    SLEN = 4'd7;
    SCLKDIV = 16'd1;
    LOOP = 1'b0;
    load(16'h0088);
    SP_EN = 1'b1;
    cyc(3);
    load(16'h0042);
    cyc(16);
    chk("mid_td", 32'(TDx), 1);
    SP_EN = 1'b0;
    cyc(1);
    chk("mid_sclk", 32'(SCLKo), 0);
    chk("mid_fs", 32'(FSo), 0);
    chk("mid_td0", 32'(TDx), 0);
    chk("mid_buf", 32'(TX_READY), 0);
    chk("mid_rxv", 32'(RX_VALID), 1);
    chk("mid_rxd", 32'(RX_DATA), 32'hBEEF);
    cyc(40);
    chk("idle_ovf", 32'(RX_OVF), 0);
    chk("idle_ufl", 32'(TX_UFL), 0);
    chk("idle_buf", 32'(TX_READY), 0);
    RST = 1'b1;
    #1;
    chk("arst_txr", 32'(TX_READY), 1);
    chk("arst_rxv", 32'(RX_VALID), 0);
    chk("arst_rxd", 32'(RX_DATA), 0);
    RST = 1'b0;
    cyc(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sport_lane_engine.md
Name: sport_lane_engine

Overview:
Parametrised serial-port shift engine for the next-generation SPORT. It generates SCLK from DSPCLK with a programmable divider and generates internal frame sync. It supports word lengths from 3 to DW bits and multichannel (TDM) framing of up to NSLOT slots, with per-slot TX/RX enable masks. It sits between the SPORT register/DMA logic (valid/ready word interfaces) and the pins, and carries over internal loopback.

Parameters:
DW, 16, maximum serial word width in bits.
NSLOT, 32, maximum TDM slots per frame.
DIVW, 16, width of the SCLK divider value.

Ports:
DSPCLK  in  1  system clock; all logic is on its rising edge.
RST  in  1  asynchronous, active-high reset.
SP_EN  in  1  port enable.
SCLKDIV  in  DIVW  SCLK period = 2*(SCLKDIV+1) DSPCLK.
SLEN  in  $clog2(DW)  word length minus 1; values below 2 are treated as 2.
MCE  in  1  multichannel enable.
SLOTS_M1  in  $clog2(NSLOT)  slots per frame minus 1; used only when MCE=1.
TSLOT_MASK  in  NSLOT  TX slot enables.
RSLOT_MASK  in  NSLOT  RX slot enables.
LOOP  in  1  internal loopback.
TX_DATA  in  DW  right-justified transmit word.
TX_VALID  in  1  transmit word offered.
TX_READY  out  1  holding buffer empty.
RX_DATA  out  DW  right-justified received word; upper bits are 0.
RX_VALID  out  1  received word available.
RX_READY  in  1  consumer accepts the received word.
TX_UFL  out  1  one-cycle underflow pulse.
RX_OVF  out  1  one-cycle overflow pulse.
RDx  in  1  serial data from pin.
TDx  out  1  serial data to pin.
SCLKo  out  1  serial clock.
FSo  out  1  frame sync.
SLOT_NUM  out  $clog2(NSLOT)  current slot.

Behaviour:
- Reset: SCLKo, FSo, TDx, RX_VALID, TX_UFL, RX_OVF are 0. RX_DATA is 0 and SLOT_NUM is 0. The holding buffer is empty, so TX_READY=1. Counters are cleared.
- Configuration capture: SCLKDIV, SLEN, MCE and SLOTS_M1 are captured on the DSPCLK edge where SP_EN rises. Changes while SP_EN=1 are ignored. The masks are sampled live at each slot start.
- Divider: the counter counts 0..SCLKDIV and produces a tick when it reaches SCLKDIV.
  - Ticks alternate between rise and fall, and SCLKo toggles on each tick.
  - The first tick after enable is a rise.
  - SCLKDIV=0 gives DSPCLK/2.
- Counters: the bit counter runs 0..SLEN and advances on fall ticks. At wrap, SLOT_NUM advances 0..SLOTS_M1 and then returns to 0. With MCE=0, SLOT_NUM stays 0 and the mask bit used is bit 0.
- FSo: high for exactly the bit-0 SCLK period of slot 0, from the rise tick to the next rise tick.
- TX holding buffer (1 deep): loaded when TX_VALID&TX_READY. TX_READY = buffer empty.
- TX slot start (rise tick of bit 0):
  - If the TSLOT_MASK bit is set and the buffer is full, the buffer moves to the shift register and the buffer empties in the same cycle.
  - If the mask bit is set and the buffer is empty, 0 is shifted and TX_UFL pulses.
  - If the mask bit is clear, TDx=0 for the whole slot and the buffer is untouched.
- TX shifting: MSB first, so bit SLEN is sent first. The data bit is presented on rise ticks.
- Same-cycle load: a TX_VALID handshake in the same cycle as a slot-start consume is accepted and refills the buffer.
- Internal receive line: RD = LOOP ? tx_bit : RDx. TDx = LOOP ? 0 : tx_bit.
- RX sampling: RD is sampled on fall ticks into the RX shifter. On the fall tick of bit SLEN of an RSLOT_MASK-enabled slot, the word completes.
- RX completion:
  - If RX_VALID=0, or RX_VALID&RX_READY in that cycle: RX_DATA is loaded and RX_VALID=1.
  - Otherwise the new word is dropped, RX_DATA is kept, and RX_OVF pulses.
- RX handshake: RX_VALID falls on RX_VALID&RX_READY unless a new word completes in the same cycle.
- SP_EN=0 (including mid-word): on the next edge, the divider, counters and shifters clear.
  - SCLKo, FSo, TDx go to 0.
  - A partial word is discarded; no RX_VALID, TX_UFL or RX_OVF results from it.
  - The TX holding buffer and RX_DATA/RX_VALID are retained.
- RST mid-operation: everything is cleared asynchronously, including both buffers.

Optional Feature:
SPORT_LSBF_EN.
- With the macro: input port LSBF (1 bit) is added and captured with the other configuration.
  - LSBF=1: TX sends bit 0 first.
  - LSBF=1: the RX shifter fills from bit 0 upward, giving the same right-justified RX_DATA.
- Without the macro: the port is absent and operation is MSB-first only.

Decomposition:
- Package sport_pkg:
  - DW/NSLOT/DIVW defaults.
  - Derived widths: SLEN_W = $clog2(DW), SLOT_W = $clog2(NSLOT).
  - Constant SLEN_MIN=2.
  - Typedef for the captured config struct.
- Sub-module sport_sclk_gen: divider, SCLKo, rise/fall tick outputs, enable clear.

Test Plan:
- Basic TX: SCLKDIV=1, SLEN=7, MCE=0, LOOP=0, TX_DATA=0xA5 → TDx = 1,0,1,0,0,1,0,1 on successive SCLK periods (4 DSPCLK each). FSo is high for the first period only.
- Loopback: LOOP=1, TX word 0x0A5 → RX_DATA=0x00A5 and RX_VALID set on the 8th fall tick. TDx stays 0 throughout.
- Multichannel: MCE=1, SLOTS_M1=3, TSLOT_MASK=0b0101, RSLOT_MASK=0b0100, LOOP=1, words 0x11 and 0x22 queued → TDx=0 in slots 1 and 3, RX_DATA=0x22 from slot 2 only, SLOT_NUM cycles 0..3.
- Underflow/overflow:
  - No TX_VALID at an enabled slot → TX_UFL is a single-cycle pulse and zeros are sent.
  - RX_READY=0 across two completed words → RX_OVF pulses once and RX_DATA holds the first word.
- Boundaries:
  - SLEN=1 → 3-bit words.
  - SLEN=15 → 16-bit words.
  - SCLKDIV=0 → SCLKo toggles every DSPCLK.
  - Simultaneous RX_READY and completion → no RX_OVF, RX_VALID stays 1.
- Disable/reset: SP_EN dropped at bit 4 → SCLKo/FSo/TDx are 0 next edge, no RX_VALID, TX buffer is still full. Asserting RST afterward → TX_READY=1 and RX_VALID=0 immediately (asynchronous).
